// File: rtl/mms_stream_reducer_if.sv
// Stream interface for mms_stream_reducer.
// Input stream:  select / in_valid / in_ready / in_data.
// Output stream: out_valid / out_ready / result (+ out_index when MMS_INDEX_EN is defined).
// Handshake: a transfer happens on a rising clk edge where valid && ready are both high.
//   A producer keeps valid and its data stable until that edge.
//   ready never depends combinationally on valid.
// The slave modport is the reducer's view; the master modport is the surrounding logic's view.
interface mms_stream_reducer_if #(
   parameter int WIDTH = 8,
   parameter int GROUP = 4
);
   logic             select;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
`ifdef MMS_INDEX_EN
   localparam int IW = $clog2(GROUP);
   logic [IW-1:0]    out_index;

   modport slave  (input  select, in_valid, in_data, out_ready,
                   output in_ready, out_valid, result, out_index);
   modport master (output select, in_valid, in_data, out_ready,
                   input  in_ready, out_valid, result, out_index);
`else
   modport slave  (input  select, in_valid, in_data, out_ready,
                   output in_ready, out_valid, result);
   modport master (output select, in_valid, in_data, out_ready,
                   input  in_ready, out_valid, result);
`endif
endinterface

// File: rtl/mms_stream_reducer.sv
// mms_stream_reducer: folds GROUP accepted beats into one unsigned min (select=1)
// or max (select=0) result and presents it on a valid/ready output stream.
// Optional feature macro: MMS_INDEX_EN adds out_index, the winner's position in the group.
// Tie handling: min keeps the earliest equal value, max takes the latest.
// state_dbg exposes the FSM state: 0 = ACCUM, 1 = HOLD.
module mms_stream_reducer #(
   parameter int WIDTH = 8,
   parameter int GROUP = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   mms_stream_reducer_if.slave   bus,
   output logic                  state_dbg
);
   localparam int CW = $clog2(GROUP);
   localparam logic [CW-1:0] LAST = CW'(GROUP - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc;
   logic             mode;
   logic             take;
`ifdef MMS_INDEX_EN
   logic [CW-1:0]    idx;
`endif

   // Incoming beat replaces the running winner (strict < for min, >= for max).
   always_comb begin
      take = 1'b0;
      if (mode) take = (bus.in_data < acc);
      else      take = (bus.in_data >= acc);
   end

   assign bus.in_ready = (state == ACCUM);
   assign state_dbg    = logic'(state);

   // Group accumulation FSM; result and out_valid are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ACCUM;
         count         <= '0;
         acc           <= '0;
         mode          <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
`ifdef MMS_INDEX_EN
         idx           <= '0;
         bus.out_index <= '0;
`endif
      end else begin
         case (state)
            ACCUM: begin
               if (bus.in_valid) begin
                  if (count == '0) begin
                     // First beat seeds the winner and latches the mode for the group.
                     acc   <= bus.in_data;
                     mode  <= bus.select;
                     count <= CW'(1);
`ifdef MMS_INDEX_EN
                     idx   <= '0;
`endif
                  end else if (count == LAST) begin
                     // Final beat goes straight to the output register.
                     bus.result    <= take ? bus.in_data : acc;
                     bus.out_valid <= 1'b1;
                     count         <= '0;
                     state         <= HOLD;
`ifdef MMS_INDEX_EN
                     bus.out_index <= take ? count : idx;
`endif
                  end else begin
                     if (take) begin
                        acc <= bus.in_data;
`ifdef MMS_INDEX_EN
                        idx <= count;
`endif
                     end
                     count <= count + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_mms_stream_reducer.sv
// Self-checking bench for mms_stream_reducer (WIDTH=8, GROUP=4).
// Directed vector table, hand-written corner sequences, then random groups
// checked against a min/max reference model through an expected-result queue.
module tb_mms_stream_reducer;
   localparam int WIDTH = 8;
   localparam int GROUP = 4;

   logic clk;
   logic reset;
   logic state_dbg;

   mms_stream_reducer_if #(.WIDTH(WIDTH), .GROUP(GROUP)) bus ();

   mms_stream_reducer #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] exp_q[$];
   int               idx_q[$];

   typedef logic [WIDTH-1:0] grp_t [GROUP];

   typedef struct {
      logic       sel;
      grp_t       d;
      logic [7:0] exp_r;
      int         exp_i;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: min -> smallest value, first position; max -> largest value, last position.
   task automatic model(input logic sel, input grp_t d, output logic [WIDTH-1:0] r, output int ix);
      int best;
      best = sel ? 256 : -1;
      for (int i = 0; i < GROUP; i++) begin
         if (sel && int'(d[i]) < best) best = int'(d[i]);
         if (!sel && int'(d[i]) > best) best = int'(d[i]);
      end
      r  = WIDTH'(best);
      ix = 0;
      if (sel) begin
         for (int i = GROUP - 1; i >= 0; i--) if (int'(d[i]) == best) ix = i;
      end else begin
         for (int i = 0; i < GROUP; i++) if (int'(d[i]) == best) ix = i;
      end
   endtask

   // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
   task automatic beat(input logic [WIDTH-1:0] d, input logic s);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.select   = s;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         chk("beat_ready_timeout", 32'(bus.in_ready), 32'd1);
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic collect(input string name);
      int n;
      logic [WIDTH-1:0] er;
      int ei;
      n = 0;
      bus.in_valid = 1'b0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() == 0) begin
         chk({name, "_queue_empty"}, 32'd0, 32'd1);
         return;
      end
      er = exp_q.pop_front();
      ei = idx_q.pop_front();
      chk({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_result"}, 32'(bus.result), 32'(er));
`ifdef MMS_INDEX_EN
      chk({name, "_out_index"}, 32'(bus.out_index), 32'(ei));
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   // ---------------- test sequence ----------------
   vec_t vecs[8];

   initial begin
      logic [WIDTH-1:0] r;
      int ix;
      grp_t g;
      logic sel;
      logic [WIDTH-1:0] held;

      vecs[0] = '{1'b0, '{8'd3,   8'd9, 8'd1, 8'd7},   8'd9,   1};
      vecs[1] = '{1'b1, '{8'd200, 8'd5, 8'd5, 8'd17},  8'd5,   1};
      vecs[2] = '{1'b0, '{8'd8,   8'd8, 8'd2, 8'd8},   8'd8,   3};
      vecs[3] = '{1'b1, '{8'd4,   8'd4, 8'd4, 8'd4},   8'd4,   0};
      vecs[4] = '{1'b0, '{8'd4,   8'd4, 8'd4, 8'd4},   8'd4,   3};
      vecs[5] = '{1'b0, '{8'd255, 8'd0, 8'd0, 8'd0},   8'd255, 0};
      vecs[6] = '{1'b1, '{8'd9,   8'd7, 8'd8, 8'd0},   8'd0,   3};
      vecs[7] = '{1'b1, '{8'd255, 8'd255, 8'd254, 8'd255}, 8'd254, 2};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.select    = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
`ifdef MMS_INDEX_EN
      chk("rst_out_index", 32'(bus.out_index), 32'd0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // Directed table: back-to-back beats, result one cycle after the last beat
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < GROUP; i++) beat(vecs[v].d[i], vecs[v].sel);
         bus.in_valid = 1'b0;
         chk($sformatf("vec%0d_latency_valid", v), 32'(bus.out_valid), 32'd1);
         chk($sformatf("vec%0d_in_ready_low", v), 32'(bus.in_ready), 32'd0);
         chk($sformatf("vec%0d_state_hold", v), 32'(state_dbg), 32'd1);
         exp_q.push_back(vecs[v].exp_r);
         idx_q.push_back(vecs[v].exp_i);
         collect($sformatf("vec%0d", v));
      end

      // Backpressure: output held, input beats ignored
      beat(8'd5, 1'b0); beat(8'd6, 1'b0); beat(8'd7, 1'b0); beat(8'd8, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd99;
      bus.select   = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_result", 32'(bus.result), 32'd8);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      exp_q.push_back(8'd8); idx_q.push_back(3);
      collect("bp");
      // The ignored 99 beats must not have leaked into this group
      beat(8'd1, 1'b1); beat(8'd1, 1'b1); beat(8'd1, 1'b1); beat(8'd1, 1'b1);
      exp_q.push_back(8'd1); idx_q.push_back(0);
      collect("bp_after");

      // select toggled after the first beat is ignored
      beat(8'd10, 1'b0); beat(8'd40, 1'b1); beat(8'd20, 1'b1); beat(8'd30, 1'b1);
      exp_q.push_back(8'd40); idx_q.push_back(1);
      collect("sel_toggle");

      // in_valid gaps between beats
      beat(8'd0, 1'b1); beat(8'd255, 1'b1);
      idle(2);
      chk("gap_no_early_valid", 32'(bus.out_valid), 32'd0);
      beat(8'd0, 1'b1); beat(8'd128, 1'b1);
      bus.in_valid = 1'b0;
      chk("gap_latency_valid", 32'(bus.out_valid), 32'd1);
      exp_q.push_back(8'd0); idx_q.push_back(0);
      collect("gap");

      // Reset mid-group drops the partial group
      beat(8'd1, 1'b0); beat(8'd2, 1'b0);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      beat(8'd1, 1'b0); beat(8'd2, 1'b0);
      bus.in_valid = 1'b0;
      chk("rst_mid_no_stale", 32'(bus.out_valid), 32'd0);
      beat(8'd3, 1'b0); beat(8'd4, 1'b0);
      bus.in_valid = 1'b0;
      chk("rst_mid_latency_valid", 32'(bus.out_valid), 32'd1);
      exp_q.push_back(8'd4); idx_q.push_back(3);
      collect("rst_mid");

      // Asynchronous reset while holding a result
      beat(8'd10, 1'b0); beat(8'd20, 1'b0); beat(8'd30, 1'b0); beat(8'd40, 1'b0);
      bus.in_valid = 1'b0;
      chk("rst_hold_pre_valid", 32'(bus.out_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_hold_async_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_hold_async_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_hold_async_result", 32'(bus.result), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_hold_quiet", 32'(bus.out_valid), 32'd0);
      end
      beat(8'd1, 1'b0); beat(8'd2, 1'b0); beat(8'd3, 1'b0); beat(8'd4, 1'b0);
      exp_q.push_back(8'd4); idx_q.push_back(3);
      collect("rst_hold");

      // Random groups against the reference model
      for (int t = 0; t < 40; t++) begin
         sel = 1'($urandom_range(0, 1));
         for (int i = 0; i < GROUP; i++) begin
            if ($urandom_range(0, 1) == 1) g[i] = WIDTH'($urandom_range(0, 3));
            else                           g[i] = WIDTH'($urandom_range(0, 255));
         end
         model(sel, g, r, ix);
         exp_q.push_back(r);
         idx_q.push_back(ix);
         for (int i = 0; i < GROUP; i++) begin
            beat(g[i], (i == 0) ? sel : 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
         held = WIDTH'($urandom_range(0, 255));
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_data  = held;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         collect($sformatf("rnd%0d", t));
      end

      if (exp_q.size() != 0) chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
